// File: rtl/mem_wr_stage_p.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wr_stage_p
//  Description : MEM/WB pipeline stage. Captures the MEM-stage pipeline word,
//                registers the write-back control decode and keeps a
//                DEPTH-entry history of recent register writes that can be
//                queried combinationally for forwarding / hazard detection.
//
//  Ports
//    clk, rst        : clock, synchronous active-high reset
//    in_valid        : in_word carries a real instruction
//    in_word         : MEM-stage pipeline word (instruction in [31:0])
//    stall           : hold stage, history and counter
//    flush           : load a bubble (wins over stall)
//    q_addr          : register number looked up in the write history
//    out_valid       : WB stage holds a real instruction
//    out_word        : captured pipeline word (0 for a bubble)
//    IoprCtr, JrWr,
//    RegWr, MemtoReg : registered write-back controls
//    wb_dst          : registered destination register number
//    q_hit, q_age    : history lookup result (youngest matching entry)
//    retired_cnt     : valid instructions captured since reset
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wr_stage_p #(
    parameter int WORD_W = 128,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    input  logic              stall,
    input  logic              flush,
    input  logic [4:0]        q_addr,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_word,
    output logic              IoprCtr,
    output logic              JrWr,
    output logic              RegWr,
    output logic              MemtoReg,
    output logic [4:0]        wb_dst,
    output logic              q_hit,
    output logic [2:0]        q_age,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_FN_JR      = 6'b001000;
    localparam logic [5:0] c_FN_JALR    = 6'b001001;

    // ------------------------------------------------------------------
    // Write-back decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_ioprctr;
    logic       w_jrwr;
    logic       w_regwr_raw;
    logic       w_memtoreg;
    logic [4:0] w_dst;
    logic       w_load;     // a real instruction enters the stage
    logic       w_adv;      // stage and history move this edge

    assign w_op    = in_word[31:26];
    assign w_funct = in_word[5:0];
    assign w_rt    = in_word[20:16];
    assign w_rd    = in_word[15:11];

    always_comb begin
        w_ioprctr   = 1'b0;
        w_jrwr      = 1'b0;
        w_regwr_raw = 1'b1;
        w_memtoreg  = 1'b0;
        w_dst       = w_rt;

        // Immediate ALU ops (001xxx), loads/stores and branches use the
        // immediate operand path.
        if (w_op[5:3] == 3'b001 ||
            w_op inside {6'b100011, 6'b101011, 6'b100000, 6'b100100,
                         6'b101000, 6'b000100, 6'b000101, 6'b000001,
                         6'b000111, 6'b000110})
            w_ioprctr = 1'b1;

        if ((w_op == c_OP_SPECIAL && w_funct == c_FN_JALR) || w_op == c_OP_JAL)
            w_jrwr = 1'b1;

        if ((w_op == c_OP_SPECIAL && w_funct == c_FN_JR) ||
            w_op inside {6'b101011, 6'b101000, 6'b000100, 6'b000101,
                         6'b000001, 6'b000111, 6'b000110, 6'b000010})
            w_regwr_raw = 1'b0;

        if (w_op inside {6'b100011, 6'b100000, 6'b100100})
            w_memtoreg = 1'b1;

        if (w_op == c_OP_JAL)
            w_dst = 5'd31;
        else if (w_op == c_OP_SPECIAL)
            w_dst = w_rd;
    end

    assign w_load = in_valid & ~flush;
    assign w_adv  = flush | ~stall;

    // Final write enable: never for bubbles and never for $0.
    logic w_regwr_fin;
    assign w_regwr_fin = w_regwr_raw & w_load & (w_dst != 5'd0);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic              r_valid;
    logic [WORD_W-1:0] r_word;
    logic              r_ioprctr;
    logic              r_jrwr;
    logic              r_regwr;
    logic              r_memtoreg;
    logic [4:0]        r_dst;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_word     <= '0;
            r_ioprctr  <= 1'b0;
            r_jrwr     <= 1'b0;
            r_regwr    <= 1'b0;
            r_memtoreg <= 1'b0;
            r_dst      <= 5'd0;
            r_cnt      <= '0;
        end else if (w_adv) begin
            r_valid    <= w_load;
            r_word     <= w_load ? in_word : '0;
            r_ioprctr  <= w_ioprctr  & w_load;
            r_jrwr     <= w_jrwr     & w_load;
            r_regwr    <= w_regwr_fin;
            r_memtoreg <= w_memtoreg & w_load;
            r_dst      <= w_load ? w_dst : 5'd0;
            if (w_load)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Write history: entry 0 mirrors the stage, older entries shift up.
    // Each entry is {we, dst[4:0]}.
    // ------------------------------------------------------------------
    logic [5:0] r_hist [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_hist[i] <= 6'd0;
        end else if (w_adv) begin
            for (int i = DEPTH - 1; i > 0; i--)
                r_hist[i] <= r_hist[i-1];
            r_hist[0] <= {w_regwr_fin, (w_load ? w_dst : 5'd0)};
        end
    end

    // Youngest match wins: scan oldest to youngest so the lowest index
    // overwrites any older hit.
    always_comb begin
        q_hit = 1'b0;
        q_age = 3'd0;
        if (q_addr != 5'd0) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (r_hist[i][5] && r_hist[i][4:0] == q_addr) begin
                    q_hit = 1'b1;
                    q_age = 3'(i);
                end
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_word    = r_word;
    assign IoprCtr     = r_ioprctr;
    assign JrWr        = r_jrwr;
    assign RegWr       = r_regwr;
    assign MemtoReg    = r_memtoreg;
    assign wb_dst      = r_dst;
    assign retired_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_stage_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wr_stage_p
//  Description : Directed self-checking bench for mem_wr_stage_p
//                (WORD_W=64, DEPTH=2, CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wr_stage_p;

    localparam int WORD_W = 64;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              stall;
    logic              flush;
    logic [4:0]        q_addr;
    logic              out_valid;
    logic [WORD_W-1:0] out_word;
    logic              IoprCtr, JrWr, RegWr, MemtoReg;
    logic [4:0]        wb_dst;
    logic              q_hit;
    logic [2:0]        q_age;
    logic [CNT_W-1:0]  retired_cnt;

    mem_wr_stage_p #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .stall(stall), .flush(flush), .q_addr(q_addr),
        .out_valid(out_valid), .out_word(out_word),
        .IoprCtr(IoprCtr), .JrWr(JrWr), .RegWr(RegWr), .MemtoReg(MemtoReg),
        .wb_dst(wb_dst), .q_hit(q_hit), .q_age(q_age),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected controls: {out_valid, IoprCtr, JrWr, RegWr, MemtoReg}
    task automatic chk_ctl(input string tag, input logic [4:0] ctl,
                           input logic [4:0] dst, input logic [63:0] word);
        chk({tag, ".ctl"}, {59'd0, out_valid, IoprCtr, JrWr, RegWr, MemtoReg}, {59'd0, ctl});
        chk({tag, ".dst"}, {59'd0, wb_dst}, {59'd0, dst});
        chk({tag, ".word"}, out_word, word);
    endtask

    task automatic chk_q(input string tag, input logic [4:0] a,
                         input logic hit, input logic [2:0] age);
        q_addr = a;
        #1;
        chk({tag, ".hit"}, {63'd0, q_hit}, {63'd0, hit});
        chk({tag, ".age"}, {61'd0, q_age}, {61'd0, age});
    endtask

    localparam logic [31:0] c_HI = 32'hDEAD_BEEF;

    // Hand-encoded instructions
    localparam logic [31:0] c_ADD_1   = {6'd0, 5'd2, 5'd3, 5'd1, 5'd0, 6'h20};
    localparam logic [31:0] c_LW_5    = {6'b100011, 5'd1, 5'd5, 16'd0};
    localparam logic [31:0] c_JAL     = {6'b000011, 26'h10};
    localparam logic [31:0] c_SW_6    = {6'b101011, 5'd1, 5'd6, 16'd4};
    localparam logic [31:0] c_ADDIU_0 = {6'b001001, 5'd1, 5'd0, 16'd4};
    localparam logic [31:0] c_ADD_7   = {6'd0, 5'd2, 5'd3, 5'd7, 5'd0, 6'h20};
    localparam logic [31:0] c_ADD_9   = {6'd0, 5'd2, 5'd3, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] c_ADD_4   = {6'd0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_word  = {c_HI, c_ADD_1};
        stall    = 1'b0;
        flush    = 1'b0;
        q_addr   = 5'd3;

        // Reset holds everything at zero even with a valid word offered
        step();
        step();
        chk_ctl("rst", 5'b00000, 5'd0, 64'd0);
        chk("rst.cnt", {60'd0, retired_cnt}, 64'd0);
        chk_q("rst.q3", 5'd3, 1'b0, 3'd0);

        // Decode sequence: lw, jal, sw
        rst = 1'b0;
        in_word = {c_HI, c_LW_5};
        step();
        chk_ctl("lw", 5'b11011, 5'd5, {c_HI, c_LW_5});
        chk("lw.cnt", {60'd0, retired_cnt}, 64'd1);

        in_word = {c_HI, c_JAL};
        step();
        chk_ctl("jal", 5'b10110, 5'd31, {c_HI, c_JAL});

        in_word = {c_HI, c_SW_6};
        step();
        chk_ctl("sw", 5'b11000, 5'd6, {c_HI, c_SW_6});
        chk("sw.cnt", {60'd0, retired_cnt}, 64'd3);
        chk_q("sw.q31", 5'd31, 1'b1, 3'd1);
        chk_q("sw.q6", 5'd6, 1'b0, 3'd0);

        // Write to $0 is suppressed but still retires
        in_word = {c_HI, c_ADDIU_0};
        step();
        chk_ctl("addiu0", 5'b11000, 5'd0, {c_HI, c_ADDIU_0});
        chk("addiu0.cnt", {60'd0, retired_cnt}, 64'd4);
        chk_q("addiu0.q0", 5'd0, 1'b0, 3'd0);

        // Capture add rd=7, then stall three cycles with new words offered
        in_word = {c_HI, c_ADD_7};
        step();
        chk_ctl("add7", 5'b10010, 5'd7, {c_HI, c_ADD_7});
        stall = 1'b1;
        in_word = {c_HI, c_LW_5};
        for (int k = 0; k < 3; k++) begin
            in_word[40 +: 8] = 8'(k);
            step();
            chk_ctl("stall", 5'b10010, 5'd7, {c_HI, c_ADD_7});
            chk("stall.cnt", {60'd0, retired_cnt}, 64'd5);
        end

        // Flush wins over stall: bubble enters, history shifts
        flush = 1'b1;
        step();
        chk_ctl("flush", 5'b00000, 5'd0, 64'd0);
        chk("flush.cnt", {60'd0, retired_cnt}, 64'd5);
        chk_q("flush.q7", 5'd7, 1'b1, 3'd1);

        // History: rd=9 then rd=4
        flush = 1'b0;
        stall = 1'b0;
        in_word = {c_HI, c_ADD_9};
        step();
        in_word = {c_HI, c_ADD_4};
        step();
        chk("hist.cnt", {60'd0, retired_cnt}, 64'd7);
        chk_q("hist.q9", 5'd9, 1'b1, 3'd1);
        chk_q("hist.q4", 5'd4, 1'b1, 3'd0);
        chk_q("hist.q7", 5'd7, 1'b0, 3'd0);

        // A bubble advance pushes rd=9 out of the 2-entry history
        in_valid = 1'b0;
        in_word = {c_HI, c_LW_5};
        step();
        chk_ctl("bubble", 5'b00000, 5'd0, 64'd0);
        chk("bubble.cnt", {60'd0, retired_cnt}, 64'd7);
        chk_q("bubble.q9", 5'd9, 1'b0, 3'd0);
        chk_q("bubble.q4", 5'd4, 1'b1, 3'd1);

        // Reset mid-operation with flush and stall also asserted
        rst = 1'b1;
        flush = 1'b1;
        stall = 1'b1;
        in_valid = 1'b1;
        step();
        chk_q("rst2.q4", 5'd4, 1'b0, 3'd0);
        chk("rst2.cnt", {60'd0, retired_cnt}, 64'd0);

        // Counter wraps at 2^CNT_W: 17 valid advances leave 1
        rst = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        in_word = {c_HI, c_ADD_1};
        for (int k = 0; k < 17; k++)
            step();
        chk("wrap.cnt", {60'd0, retired_cnt}, 64'd1);
        chk_q("wrap.q1", 5'd1, 1'b1, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wr_stage_p.md
# mem_wr_stage_p

Parametrised MEM/WB pipeline stage for the MIPS pipeline: captures the MEM-stage pipeline word, registers the write-back control decode, and keeps a DEPTH-entry history of recent register writes for forwarding and hazard queries. It sits between the memory stage and the register file write port. It replaces the purely combinational write-back decode with a stallable, flushable, valid-qualified stage.

## Interface
- WORD_W, 128, pipeline word width; instruction occupies bits [31:0], WORD_W ≥ 32
- DEPTH, 2, write-history entries (entry 0 = current WB instruction), 1..8
- CNT_W, 32, retired-instruction counter width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_word holds a real instruction
- in_word  input  WORD_W  MEM-stage pipeline word
- stall  input  1  hold stage and history
- flush  input  1  load a bubble into the stage; overrides stall
- q_addr  input  5  register number to look up in history
- out_valid  output  1  registered; WB stage holds a real instruction
- out_word  output  WORD_W  registered copy of captured word
- IoprCtr, JrWr, RegWr, MemtoReg  output  1 each  registered write-back controls
- wb_dst  output  5  registered destination register number
- q_hit  output  1  combinational; q_addr matches a pending write in history
- q_age  output  3  combinational; index of youngest matching entry, 0 when no hit
- retired_cnt  output  CNT_W  valid instructions captured since reset

## Operation
- Fields: op = word[31:26], funct = word[5:0], rt = word[20:16], rd = word[15:11].
- IoprCtr = 1 for op in {001000..001111, 100011, 101011, 100000, 100100, 101000, 000100, 000101, 000001, 000111, 000110}.
- JrWr = 1 for jalr (op 000000, funct 001001) or jal (op 000011).
- RegWr raw = 0 for jr (op 000000, funct 001000), op in {101011, 101000, 000100, 000101, 000001, 000111, 000110, 000010}; 1 otherwise.
- MemtoReg = 1 for op in {100011, 100000, 100100}.
- Destination: jal → 31; op 000000 (incl. jalr) → rd; otherwise rt.
- Final RegWr = raw RegWr AND in_valid AND (destination ≠ 0). Writes to $0 never assert RegWr.
- Bubble (in_valid=0, flush, or reset): out_valid, all four controls, wb_dst = 0; out_word = 0.
- Advance (stall=0 or flush=1): stage loads new decode; history shifts entry i → i+1, entry DEPTH-1 discarded; entry 0 gets {RegWr, wb_dst} of the new contents.
- Stall (stall=1, flush=0): stage, history, counter all hold.
- Query: q_hit = 1 iff some entry i has RegWr=1 and dst = q_addr, with q_addr ≠ 0. q_age = lowest such i. q_addr = 0 → q_hit = 0, q_age = 0.
- retired_cnt increments by 1 on every advance loading in_valid=1 with flush=0; wraps 2^CNT_W−1 → 0.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Query path combinational from registered history only; no input-to-q_hit path except q_addr.
- Reset: all outputs and every history entry 0, retired_cnt = 0, on the first edge with rst=1; rst overrides flush and stall.
- Flush and stall together: flush wins; bubble enters, history shifts.
- Reset mid-operation: pending history discarded; q_hit = 0 from the cycle after reset.
- DEPTH=1: history is entry 0 only; q_age always 0.

## Test plan
- Reset: hold rst with in_valid=1, add $1,$2,$3 word → all outputs 0, retired_cnt 0, q_hit 0 for q_addr 3.
- Decode: lw $5 (op 100011) then jal then sw → cycle+1: IoprCtr=1, MemtoReg=1, RegWr=1, wb_dst=5; next: JrWr=1, RegWr=1, wb_dst=31; next: IoprCtr=1, RegWr=0.
- $0 suppression: addiu $0,$1,4 with in_valid=1 → RegWr=0, out_valid=1, retired_cnt +1.
- Stall/flush: capture add rd=7, stall 3 cycles with new words on in_word → outputs unchanged, retired_cnt unchanged; assert flush+stall → out_valid=0, entry 1 holds dst 7.
- History (DEPTH=2): write rd=9 then rd=4 → q_addr 9: q_hit=1, q_age=1; q_addr 4: q_age=0; one more advance → q_addr 9 hit=0.
- Counter wrap (CNT_W=4): 17 valid advances → retired_cnt = 1.
